// File: rtl/pc_gen_unit.sv
// pc_gen_unit: program-counter generator for the RV32I fetch stage.
//
// Holds the architectural PC and picks the next PC each cycle from trap vector,
// branch/jump redirect, stall (hold) or sequential increment. A small FSM
// (BOOT -> RUN <-> HALT) controls when the PC is presented as valid.
//
// Optional feature macro: PC_MISALIGN_CHK_EN
//   defined   : a redirect whose target has bit1 set is turned into a trap,
//               and misalign_o pulses for one cycle.
//   undefined : no check; misalign_o is tied low.
//
// Ports:
//   clk             core clock, all state on rising edge
//   reset           synchronous active-high reset
//   stall           hold PC (hazard / fetch not ready)
//   redirect_valid  taken branch/jump this cycle
//   redirect_target branch/jump target (bit0 is always cleared)
//   trap_req        take trap this cycle
//   halt_req        enter HALT
//   resume          leave HALT
//   pc_out          current PC presented to fetch
//   pc_plus_inc     pc_out + INC, combinational, wraps mod 2^WIDTH
//   pc_valid        pc_out is a fetchable address
//   epc_out         PC captured at the last trap
//   misalign_o      one-cycle pulse when a misaligned redirect was trapped

module pc_gen_unit #(
  parameter int unsigned      WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0] TRAP_VECTOR  = WIDTH'(32'h0000_0100),
  parameter int unsigned      INC          = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_target,
  input  logic             trap_req,
  input  logic             halt_req,
  input  logic             resume,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] pc_plus_inc,
  output logic             pc_valid,
  output logic [WIDTH-1:0] epc_out,
  output logic             misalign_o
);

  typedef enum logic [1:0] {
    StBoot = 2'b00,
    StRun  = 2'b01,
    StHalt = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic             valid_q, valid_d;
  logic             mis_d;

  assign pc_plus_inc = pc_q + WIDTH'(INC);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    epc_d   = epc_q;
    mis_d   = 1'b0;
    case (state_q)
      // BOOT only spends one cycle so the first valid fetch is RESET_VECTOR.
      StBoot: state_d = StRun;
      StRun: begin
        if (trap_req) begin
          pc_d  = TRAP_VECTOR;
          epc_d = pc_q;
`ifdef PC_MISALIGN_CHK_EN
        end else if (redirect_valid && redirect_target[1]) begin
          pc_d  = TRAP_VECTOR;
          epc_d = pc_q;
          mis_d = 1'b1;
`endif
        end else if (redirect_valid) begin
          pc_d = {redirect_target[WIDTH-1:1], 1'b0};
        end else if (!stall) begin
          pc_d = pc_plus_inc;
        end
        // The PC update above still applies in the cycle halt is requested.
        if (halt_req) begin
          state_d = StHalt;
        end
      end
      StHalt: begin
        if (resume) begin
          state_d = StRun;
        end
      end
      default: state_d = StBoot;
    endcase
    valid_d = (state_d == StRun);
  end

`ifdef PC_MISALIGN_CHK_EN
  logic mis_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      mis_q <= 1'b0;
    end else begin
      mis_q <= mis_d;
    end
  end

  assign misalign_o = mis_q;
`else
  logic unused_mis;
  assign unused_mis = mis_d;
  assign misalign_o = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StBoot;
      pc_q    <= RESET_VECTOR;
      epc_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      valid_q <= valid_d;
    end
  end

  assign pc_out   = pc_q;
  assign epc_out  = epc_q;
  assign pc_valid = valid_q;

endmodule

// File: tb/tb_pc_gen_unit.sv
module tb_pc_gen_unit;

  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] TV = 32'h0000_0100;
`ifdef PC_MISALIGN_CHK_EN
  localparam bit MisEn = 1'b1;
`else
  localparam bit MisEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic        trap_req = 1'b0;
  logic        halt_req = 1'b0;
  logic        resume = 1'b0;
  logic [31:0] pc_out, pc_plus_inc, epc_out;
  logic        pc_valid, misalign_o;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  // Reference model: architectural view of the generator.
  logic [31:0] m_pc, m_epc;
  bit          m_mis, m_boot, m_halt;

  pc_gen_unit dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .trap_req        (trap_req),
    .halt_req        (halt_req),
    .resume          (resume),
    .pc_out          (pc_out),
    .pc_plus_inc     (pc_plus_inc),
    .pc_valid        (pc_valid),
    .epc_out         (epc_out),
    .misalign_o      (misalign_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_apply();
    bit mis;
    if (reset) begin
      m_pc = RV; m_epc = 32'h0; m_mis = 1'b0; m_boot = 1'b1; m_halt = 1'b0;
    end else if (m_boot) begin
      m_boot = 1'b0; m_mis = 1'b0;
    end else if (m_halt) begin
      m_mis = 1'b0;
      if (resume) m_halt = 1'b0;
    end else begin
      mis = MisEn && redirect_valid && redirect_target[1] && !trap_req;
      m_mis = mis;
      if (trap_req || mis) begin
        m_epc = m_pc;
        m_pc  = TV;
      end else if (redirect_valid) begin
        m_pc = redirect_target & 32'hFFFF_FFFE;
      end else if (!stall) begin
        m_pc = m_pc + 32'd4;
      end
      if (halt_req) m_halt = 1'b1;
    end
  endtask

  task automatic step(input bit r, input bit st, input bit rv, input logic [31:0] rt,
                      input bit tr, input bit hr, input bit rs);
    reset = r; stall = st; redirect_valid = rv; redirect_target = rt;
    trap_req = tr; halt_req = hr; resume = rs;
    @(posedge clk);
    model_apply();
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("pc_out", pc_out, m_pc);
      chk("pc_plus_inc", pc_plus_inc, m_pc + 32'd4);
      chk("pc_valid", {31'b0, pc_valid}, {31'b0, !m_boot && !m_halt});
      chk("epc_out", epc_out, m_epc);
      chk("misalign_o", {31'b0, misalign_o}, {31'b0, m_mis});
    end
  end

  initial begin
    logic [31:0] rt;
    logic [31:0] prev_pc;
    // 1. reset, BOOT, then sequential fetch
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk_en = 1'b1;
    chk("t1_boot_pc", pc_out, 32'h0);
    chk("t1_boot_valid", {31'b0, pc_valid}, 32'h0);
    chk("t1_boot_epc", epc_out, 32'h0);
    idle();
    chk("t1_pc0", pc_out, 32'h0);
    chk("t1_valid", {31'b0, pc_valid}, 32'h1);
    idle(); chk("t1_pc4", pc_out, 32'h4);
    idle(); chk("t1_pc8", pc_out, 32'h8);
    // 2. redirect wins over stall, bit0 cleared
    step(1'b0, 1'b1, 1'b1, 32'h0000_2001, 1'b0, 1'b0, 1'b0);
    chk("t2_redir", pc_out, 32'h0000_2000);
    idle(); chk("t2_inc", pc_out, 32'h0000_2004);
    // 3. trap beats redirect
    step(1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 1'b0, 1'b0);
    chk("t3_pc40", pc_out, 32'h40);
    step(1'b0, 1'b0, 1'b1, 32'h5000, 1'b1, 1'b0, 1'b0);
    chk("t3_trap_pc", pc_out, 32'h100);
    chk("t3_epc", epc_out, 32'h40);
    // 4. halt freezes PC/EPC despite trap and redirect
    step(1'b0, 1'b0, 1'b1, 32'h10, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("t4_halt_pc", pc_out, 32'h14);
    chk("t4_halt_valid", {31'b0, pc_valid}, 32'h0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 1'b1, 32'h3000, 1'b1, 1'b0, 1'b0);
      chk("t4_frozen_pc", pc_out, 32'h14);
      chk("t4_frozen_epc", epc_out, 32'h40);
    end
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("t4_resume_pc", pc_out, 32'h14);
    chk("t4_resume_valid", {31'b0, pc_valid}, 32'h1);
    idle(); chk("t4_next", pc_out, 32'h18);
    // 5. wrap-around, then reset mid-operation
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0);
    chk("t5_plus_wrap", pc_plus_inc, 32'h0);
    idle(); chk("t5_wrap", pc_out, 32'h0);
    step(1'b1, 1'b0, 1'b1, 32'h7000, 1'b1, 1'b1, 1'b0);
    chk("t5_rst_pc", pc_out, RV);
    chk("t5_rst_valid", {31'b0, pc_valid}, 32'h0);
    chk("t5_rst_epc", epc_out, 32'h0);
    // 6. misaligned redirect
    idle();
    step(1'b0, 1'b0, 1'b1, 32'h20, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'h302, 1'b0, 1'b0, 1'b0);
    chk("t6_pc", pc_out, MisEn ? 32'h100 : 32'h302);
    chk("t6_epc", epc_out, MisEn ? 32'h20 : 32'h0);
    chk("t6_mis", {31'b0, misalign_o}, {31'b0, MisEn});
    idle();
    chk("t6_mis_pulse", {31'b0, misalign_o}, 32'h0);
    chk("t6_next", pc_out, MisEn ? 32'h104 : 32'h306);
    prev_pc = MisEn ? 32'h104 : 32'h306;
    step(1'b0, 1'b0, 1'b1, 32'h302, 1'b1, 1'b0, 1'b0);
    chk("t6_trap_pc", pc_out, 32'h100);
    chk("t6_trap_epc", epc_out, prev_pc);
    chk("t6_trap_mis", {31'b0, misalign_o}, 32'h0);
    // randomized phase against the model
    for (int i = 0; i < 3000; i++) begin
      rt = $urandom;
      if ($urandom_range(3, 0) == 0) rt = 32'hFFFF_FFF0 | (rt & 32'hF);
      if ($urandom_range(1, 0) == 0) rt[1] = 1'b0;
      step($urandom_range(99, 0) == 0, $urandom_range(3, 0) == 0,
           $urandom_range(3, 0) == 0, rt, $urandom_range(15, 0) == 0,
           $urandom_range(19, 0) == 0, $urandom_range(3, 0) == 0);
    end
    idle();
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
